// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//
// Shared types for the show-ahead FIFO.
//
//   fifo_op_e     : what a clock edge does to the queue once the raw wr/rd
//                   requests have been qualified against full/empty.
//   fifo_flags_t  : the four occupancy flags, bundled so the decode lives in
//                   one place and can be probed as a single vector.
//   fifo_decode_op: packs qualified push/pop strobes into a fifo_op_e.
// ---------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic almost_empty;
    logic empty;
  } fifo_flags_t;

  // push/pop must already be qualified (push only when there is room or a
  // pop frees a slot, pop only when not empty).
  function automatic fifo_op_e fifo_decode_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
//
// DEPTH x DBITS storage for the FIFO. One synchronous write port and one
// asynchronous (combinational) read port, so the head entry addressed by the
// registered read pointer is visible in the same cycle.
//
// Ports:
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write address (ABITS)
//   wdata : write data (DBITS)
//   raddr : read address (ABITS)
//   rdata : read data (DBITS), combinational from raddr
//
// Contents are intentionally not reset; the FIFO only ever exposes entries
// that were written since the last reset.
// ---------------------------------------------------------------------------
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DBITS = 8,
  parameter int ABITS = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DBITS-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [DBITS-1:0] rdata
);

  localparam int DEPTH = 1 << ABITS;

  logic [DBITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo
//
// Single-clock show-ahead FIFO. The head entry is always presented on dout,
// so a consumer can use it and pop it in the same cycle. Used in the VGA read
// path to remember the SDRAM address of each outstanding read request.
//
// Parameters:
//   DBITS    : data width
//   ABITS    : pointer width, depth = 2**ABITS
//   AE_LEVEL : almost_empty when occupancy <= AE_LEVEL
//   AF_LEVEL : almost_full  when occupancy >= AF_LEVEL
//
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low; discards all queued entries
//   wr           : push din at the rising edge
//   rd           : pop the head entry at the rising edge
//   din          : write data
//   dout         : head entry (meaningless while empty)
//   full         : occupancy == DEPTH
//   empty        : occupancy == 0
//   almost_full  : occupancy >= AF_LEVEL
//   almost_empty : occupancy <= AE_LEVEL
//
// Handshake: a push is taken when wr is high and the FIFO is not full, or is
// full but rd pops in the same cycle. A pop is taken when rd is high and the
// FIFO is not empty; a rd on an empty FIFO is ignored even if wr is high.
// Dropped requests change no state.
// ---------------------------------------------------------------------------
module fifo
  import fifo_pkg::*;
#(
  parameter int DBITS    = 8,
  parameter int ABITS    = 5,
  parameter int AE_LEVEL = 1,
  parameter int AF_LEVEL = (1 << ABITS) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [DBITS-1:0] din,
  output logic [DBITS-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int DEPTH = 1 << ABITS;

  localparam logic [ABITS:0] DEPTH_CNT = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] AE_CNT    = (ABITS+1)'(AE_LEVEL);
  localparam logic [ABITS:0] AF_CNT    = (ABITS+1)'(AF_LEVEL);

  logic [ABITS-1:0] wp;
  logic [ABITS-1:0] rp;
  logic [ABITS:0]   count;

  logic        push;
  logic        pop;
  fifo_op_e    op;
  fifo_flags_t flags;

  // -------------------------------------------------------------------------
  // Flags: pure decodes of the registered count, so they only move after a
  // clock edge or reset and never follow wr/rd combinationally.
  // -------------------------------------------------------------------------
  always_comb begin
    flags              = '0;
    flags.empty        = (count == '0);
    flags.full         = (count == DEPTH_CNT);
    flags.almost_empty = (count <= AE_CNT);
    flags.almost_full  = (count >= AF_CNT);
  end

  assign empty        = flags.empty;
  assign full         = flags.full;
  assign almost_empty = flags.almost_empty;
  assign almost_full  = flags.almost_full;

  // -------------------------------------------------------------------------
  // Request qualification. When full, a simultaneous pop frees the slot the
  // write pointer is sitting on (wp == rp), so the push can go ahead: the
  // popped word is read combinationally this cycle and overwritten at the
  // edge. When empty, the pop is ignored and only the push happens.
  // -------------------------------------------------------------------------
  assign pop  = rd && !flags.empty;
  assign push = wr && (!flags.full || pop);
  assign op   = fifo_decode_op(push, pop);

  // -------------------------------------------------------------------------
  // Pointers and occupancy. Full vs. empty is told apart by count, since the
  // pointers are equal in both cases.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  fifo_ram #(
    .DBITS (DBITS),
    .ABITS (ABITS)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wp),
    .wdata (din),
    .raddr (rp),
    .rdata (dout)
  );

  // Occupancy can never exceed the depth.
  count_in_range_a: assert property (@(posedge clk) disable iff (!reset)
    count <= DEPTH_CNT);

endmodule

// File: tb/tb_fifo.sv
// ---------------------------------------------------------------------------
// tb_fifo : bench for the show-ahead FIFO at the VGA configuration (26-bit).
// The reference is a plain queue: pushes append, pops remove the front,
// occupancy is the queue size.
// ---------------------------------------------------------------------------
module tb_fifo;

  localparam int DBITS = 26;
  localparam int ABITS = 5;
  localparam int DEPTH = 32;

  logic             clk;
  logic             reset;
  logic             wr;
  logic             rd;
  logic [DBITS-1:0] din;
  logic [DBITS-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;

  int total = 0;
  int bad   = 0;

  logic [DBITS-1:0] exp_q[$];

  fifo #(
    .DBITS (DBITS),
    .ABITS (ABITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .din          (din),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  // clock / reset -----------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker -----------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Compare all outputs against the queue model (called at negedge).
  task automatic check_model(input string tag);
    int n;
    n = exp_q.size();
    check({tag, "/empty"},  32'(empty),        32'(n == 0));
    check({tag, "/full"},   32'(full),         32'(n == DEPTH));
    check({tag, "/ae"},     32'(almost_empty), 32'(n <= 1));
    check({tag, "/af"},     32'(almost_full),  32'(n >= DEPTH - 1));
    if (n > 0) begin
      check({tag, "/dout"}, 32'(dout), 32'(exp_q[0]));
    end
  endtask

  // driver: one clock cycle, entered and left at a falling edge ------------
  task automatic step(input logic w, input logic r, input logic [DBITS-1:0] d, input string tag);
    bit pop_ok;
    bit push_ok;
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    pop_ok  = r && (exp_q.size() > 0);
    push_ok = w && ((exp_q.size() < DEPTH) || pop_ok);
    if (pop_ok)  void'(exp_q.pop_front());
    if (push_ok) exp_q.push_back(d);
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    check_model(tag);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step(1'b0, 1'b1, '0, tag);
  endtask

  // stimulus ----------------------------------------------------------------
  initial begin
    logic [DBITS-1:0] v;
    int bias_w;
    int bias_r;

    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = '0;
    repeat (3) @(negedge clk);
    check_model("reset_state");
    reset = 1'b1;
    @(negedge clk);
    check_model("after_release");

    // reset mid-stream with 5 entries queued
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 26'(16'hA0 + i), "rst_fill");
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    check("rst_async_empty", 32'(empty),        32'd1);
    check("rst_async_full",  32'(full),         32'd0);
    check("rst_async_ae",    32'(almost_empty), 32'd1);
    check("rst_async_af",    32'(almost_full),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 26'h0A, "rst_first_wr");
    check("rst_first_dout", 32'(dout), 32'h0A);
    drain("rst_drain");

    // fill to full, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 26'(i), "fill");
      if (i == DEPTH - 2) begin
        check("fill31_af",   32'(almost_full), 32'd1);
        check("fill31_full", 32'(full),        32'd0);
      end
    end
    check("fill32_full", 32'(full), 32'd1);
    step(1'b1, 1'b0, 26'h3FF, "overflow");
    check("overflow_head", 32'(dout), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 32'(dout), 32'(i));
      step(1'b0, 1'b1, '0, "drain");
    end
    check("drain_empty", 32'(empty), 32'd1);

    // show-ahead
    step(1'b1, 1'b0, 26'h1234567, "sa_wr0");
    step(1'b1, 1'b0, 26'h0000008, "sa_wr1");
    check("sa_head0", 32'(dout), 32'h1234567);
    step(1'b0, 1'b1, '0, "sa_rd");
    check("sa_head1", 32'(dout), 32'h0000008);
    drain("sa_drain");

    // simultaneous push/pop at occupancy 3: output lags input by 3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 26'(100 + i), "both_pre");
    for (int i = 103; i < 203; i++) begin
      check("both_lag", 32'(dout), 32'(i - 3));
      step(1'b1, 1'b1, 26'(i), "both");
      check("both_not_empty", 32'(empty), 32'd0);
    end
    drain("both_drain");

    // full with push+pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 26'(500 + i), "full2_fill");
    step(1'b1, 1'b1, 26'h2ABCDE, "full_both");
    check("full_both_full", 32'(full), 32'd1);
    check("full_both_head", 32'(dout), 32'd501);
    for (int i = 1; i < DEPTH; i++) begin
      check("full_both_order", 32'(dout), 32'(500 + i));
      step(1'b0, 1'b1, '0, "full_both_drain");
    end
    check("full_both_tail", 32'(dout), 32'h2ABCDE);
    step(1'b0, 1'b1, '0, "full_both_last");

    // read while empty, then wrap the pointers twice
    step(1'b0, 1'b1, '0, "rd_empty");
    check("rd_empty_stays", 32'(empty), 32'd1);
    for (int i = 0; i < 70; i++) begin
      v = 26'($urandom);
      step(1'b1, 1'b0, v, "wrap_push");
      check("wrap_dout", 32'(dout), 32'(v));
      step(1'b0, 1'b1, '0, "wrap_pop");
    end

    // random traffic with shifting bias to visit full and empty often
    for (int seg = 0; seg < 6; seg++) begin
      bias_w = (seg % 2 == 0) ? 80 : 30;
      bias_r = (seg % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 100; i++) begin
        step(($urandom_range(0, 99) < bias_w) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < bias_r) ? 1'b1 : 1'b0,
             26'($urandom), "random");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo.md
# fifo

Synchronous single-clock FIFO with show-ahead output and full/empty/almost flags. In the VGA read path, `vga_master` uses it to queue the 26-bit SDRAM addresses of outstanding read requests, so each returning data word can be matched to its address. The head entry is visible on `dout` before it is popped, so the consumer can use the address in the same cycle it pops.

## Interface
- `DBITS`, default 8: data width in bits. The VGA path instantiates it with 26.
- `ABITS`, default 5: address width; depth is `DEPTH = 2**ABITS` entries (32).
- `AE_LEVEL`, default 1: `almost_empty` is asserted when occupancy ≤ `AE_LEVEL`.
- `AF_LEVEL`, default `DEPTH-1` (31): `almost_full` is asserted when occupancy ≥ `AF_LEVEL`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, asynchronous, active-low; clock `clk`.
- `wr` in 1: push `din` at the rising edge.
- `rd` in 1: pop the head entry at the rising edge.
- `din` in `DBITS`: write data.
- `dout` out `DBITS`: current head entry (show-ahead).
- `full` out 1: occupancy == `DEPTH`.
- `empty` out 1: occupancy == 0.
- `almost_full` out 1: occupancy ≥ `AF_LEVEL`.
- `almost_empty` out 1: occupancy ≤ `AE_LEVEL`.

## Operation
- **State:** circular storage of `DEPTH` words, write pointer `wp` (`ABITS`), read pointer `rp` (`ABITS`), occupancy `count` (`ABITS+1` bits, range 0..`DEPTH`).
- **Write:** `wr` with `!full`: `mem[wp] <= din`, `wp` increments modulo `DEPTH`.
- **Read:** `rd` with `!empty`: `rp` increments modulo `DEPTH`.
- **Output:** `dout = mem[rp]`, combinational from the registered pointer. No read latency; the popped value is the one on `dout` during the `rd` cycle.
- **Simultaneous `wr` and `rd`:**
  - Not empty and not full: both operations happen and `count` is unchanged.
  - Full: the read frees a slot, so the write is also accepted; `count` stays `DEPTH`.
  - Empty: the read is ignored and the write is accepted; `count` becomes 1.
- **Overflow:** `wr` while full without `rd` is dropped; no state changes and stored data is not corrupted.
- **Underflow:** `rd` while empty is ignored. `dout` then shows stale `mem[rp]` and has no meaning; the consumer must check `empty`.
- **Wrap-around:** pointers roll from `DEPTH-1` to 0 with no gap; full and empty are distinguished by `count`, not by pointer equality.
- **Flags:** all are combinational decodes of `count` and do not depend on `wr`/`rd` in the current cycle.

## Timing
- **Reset value (asynchronous on falling `reset`):** `wp=0`, `rp=0`, `count=0`, so `empty=1`, `almost_empty=1`, `full=0`, `almost_full=0`. Memory contents are not cleared, so `dout` is undefined until the first write.
- **Reset mid-operation:** all queued entries are discarded immediately. The first write after `reset` deasserts lands in `mem[0]`.
- **Write-to-read latency:** a word written at edge N appears on `dout` and `empty` falls right after edge N, so it can be popped at edge N+1.
- **Flag timing:** flags change only after a clock edge (or at reset) and are never glitched by `wr`/`rd`.
- **Throughput:** one push and one pop per cycle, sustained.

## Structure
- No shared package is needed; the parameters are local to the block.
- One sub-module is natural: `fifo_ram`, a `DEPTH`×`DBITS` array with a synchronous write port and an asynchronous read port.
- The pointer, count and flag control logic stays in `fifo`.

## Test plan
- **Reset:** assert `reset`=0 mid-stream with 5 entries queued → `empty=1`, `full=0`, `almost_empty=1` immediately. After release, write 0x0A → `dout=0x0A` next cycle.
- **Fill to full:** 32 writes of 0..31 with no reads → `almost_full` rises after the 31st write, `full` after the 32nd. A 33rd write of 0x3FF is dropped; draining yields 0..31 in order, then `empty=1`.
- **Show-ahead:** write 0x1234567, then 0x0000008 → `dout=0x1234567` before any `rd`. One `rd` → `dout=0x0000008`.
- **Simultaneous push/pop:** with 3 entries queued, hold `wr`=`rd`=1 for 100 cycles with an incrementing `din` → `count` stays 3 and the output sequence lags the input by 3.
- **Full with `rd`+`wr`:** when full, pulse both → `full` stays 1, the head advances, and the new word is appended.
- **Empty with `rd`, and wrap-around:** `rd` while empty → no change, `empty` stays 1. Run 70 push/pop pairs so the pointers wrap twice → order is preserved and there is no spurious `full` or `empty`.
